// File: rtl/oflow_pe_pkg.sv
// Shared constants and state encoding for the per-PE FE/registration controller.
package oflow_pe_pkg;

   localparam int FE_LAT   = 4;   // FE datapath depth in cycles
   localparam int CAND_MAX = 48;  // max previous-frame candidates per registration
   localparam int CAND_AW  = 6;   // candidate address width
   localparam int SCORE_W  = 16;  // unsigned score width, lower is better
   localparam int ID_W     = 12;  // object ID width

   localparam logic [ID_W-1:0]    NO_MATCH   = '1;
   localparam logic [SCORE_W-1:0] SCORE_NONE = '1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FE_RUN,
      ST_FE_DONE,
      ST_REG_RD,
      ST_REG_DRAIN,
      ST_REG_DONE
   } pe_ctrl_state_t;

endpackage

// File: rtl/oflow_pe_min_tracker.sv
// Running strict arg-min over a stream of (score, id) pairs.
// Ties keep the earlier entry; an all-ones score can never displace the
// initial all-ones value, so such candidates never produce a match.
module oflow_pe_min_tracker #(
   parameter int SCORE_W = 16,
   parameter int ID_W    = 12
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               clear,
   input  logic               valid,
   input  logic [SCORE_W-1:0] score,
   input  logic [ID_W-1:0]    id,
   output logic [SCORE_W-1:0] best_score,
   output logic [ID_W-1:0]    best_id
);

   // Hold the best-so-far; reset/clear park it at the no-match sentinel.
   always_ff @(posedge clk) begin
      if (reset || clear) begin
         best_score <= '1;
         best_id    <= '1;
      end else if (valid && (score < best_score)) begin
         best_score <= score;
         best_id    <= id;
      end
   end

endmodule

// File: rtl/oflow_pe_ctrl.sv
// Per-PE controller: FE latency window followed by a candidate sweep that
// tracks the best-scoring previous-frame object. Done flags are levels so the
// sequencers can AND them across the PE array.
module oflow_pe_ctrl
   import oflow_pe_pkg::*;
#(
   parameter int P_FE_LAT   = FE_LAT,
   parameter int P_CAND_MAX = CAND_MAX,
   parameter int P_CAND_AW  = CAND_AW,
   parameter int P_SCORE_W  = SCORE_W,
   parameter int P_ID_W     = ID_W
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start_fe,
   input  logic                 start_registration,
   input  logic                 bbox_valid,
   input  logic [P_CAND_AW-1:0] num_cand,
   output logic                 cand_rd_en,
   output logic [P_CAND_AW-1:0] cand_addr,
   input  logic [P_SCORE_W-1:0] cand_score,
   input  logic [P_ID_W-1:0]    cand_id,
   output logic                 fe_busy,
   output logic                 done_fe,
   output logic                 done_registration,
   output logic [P_ID_W-1:0]    best_id,
   output logic [P_SCORE_W-1:0] best_score,
   output logic                 protocol_err
);

   localparam int FE_CW = $clog2(P_FE_LAT + 1);
   localparam int CN_W  = P_CAND_AW + 1;   // holds CAND_MAX even when it is 2**CAND_AW

   localparam logic [FE_CW-1:0]     FE_LOAD = FE_CW'(P_FE_LAT - 1);
   localparam logic [FE_CW-1:0]     FE_ONE  = FE_CW'(1);
   localparam logic [CN_W-1:0]      CN_MAX  = CN_W'(P_CAND_MAX);
   localparam logic [CN_W-1:0]      CN_ONE  = CN_W'(1);
   localparam logic [P_CAND_AW-1:0] AD_ONE  = P_CAND_AW'(1);

   pe_ctrl_state_t   state;
   logic [FE_CW-1:0] fe_cnt;
   logic [CN_W-1:0]  rd_left;   // reads still to issue
   logic [CN_W-1:0]  n_clamp;
   logic             sc_vld;    // cand_score/cand_id carry a real candidate this cycle
   logic             fe_acc;
   logic             reg_acc;

   // Start acceptance and clamped candidate count.
   always_comb begin
      fe_acc  = start_fe && ((state == ST_IDLE) || (state == ST_REG_DONE));
      reg_acc = start_registration && (state == ST_FE_DONE);
      n_clamp = ({1'b0, num_cand} > CN_MAX) ? CN_MAX : {1'b0, num_cand};
   end

   // Sequencer FSM with registered outputs; an idle slot reuses FE_RUN for a
   // single cycle with fe_busy low so done_fe still rises one cycle later.
   always_ff @(posedge clk) begin
      if (reset) begin
         state             <= ST_IDLE;
         fe_cnt            <= '0;
         rd_left           <= '0;
         sc_vld            <= 1'b0;
         cand_rd_en        <= 1'b0;
         cand_addr         <= '0;
         fe_busy           <= 1'b0;
         done_fe           <= 1'b0;
         done_registration <= 1'b0;
         protocol_err      <= 1'b0;
      end else begin
         protocol_err <= (start_fe && !fe_acc) || (start_registration && !reg_acc);
         sc_vld       <= cand_rd_en;
         case (state)
            ST_IDLE, ST_REG_DONE: begin
               if (fe_acc) begin
                  state             <= ST_FE_RUN;
                  done_fe           <= 1'b0;
                  done_registration <= 1'b0;
                  fe_busy           <= bbox_valid;
                  fe_cnt            <= bbox_valid ? FE_LOAD : '0;
               end
            end
            ST_FE_RUN: begin
               if (fe_cnt == '0) begin
                  state   <= ST_FE_DONE;
                  fe_busy <= 1'b0;
                  done_fe <= 1'b1;
               end else begin
                  fe_cnt <= fe_cnt - FE_ONE;
               end
            end
            ST_FE_DONE: begin
               if (reg_acc) begin
                  cand_addr  <= '0;
                  cand_rd_en <= 1'b0;
                  if (!bbox_valid || (n_clamp == '0)) begin
                     state   <= ST_REG_DRAIN;
                     rd_left <= '0;
                  end else begin
                     state   <= ST_REG_RD;
                     rd_left <= n_clamp;
                  end
               end
            end
            ST_REG_RD: begin
               if (rd_left != '0) begin
                  cand_rd_en <= 1'b1;
                  if (cand_rd_en) cand_addr <= cand_addr + AD_ONE;
                  rd_left <= rd_left - CN_ONE;
               end else begin
                  cand_rd_en <= 1'b0;
                  state      <= ST_REG_DRAIN;
               end
            end
            ST_REG_DRAIN: begin
               // Last score is consumed by the tracker on this same edge.
               state             <= ST_REG_DONE;
               done_registration <= 1'b1;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   oflow_pe_min_tracker #(
      .SCORE_W (P_SCORE_W),
      .ID_W    (P_ID_W)
   ) u_min (
      .clk        (clk),
      .reset      (reset),
      .clear      (reg_acc),
      .valid      (sc_vld),
      .score      (cand_score),
      .id         (cand_id),
      .best_score (best_score),
      .best_id    (best_id)
   );

endmodule

// File: tb/tb_oflow_pe_ctrl.sv
// Directed + randomized bench for oflow_pe_ctrl: one standalone PE plus a
// 24-PE array with two idle slots sharing one candidate buffer model.
module tb_oflow_pe_ctrl;
   import oflow_pe_pkg::*;

   localparam int NPE = 24;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic               reset = 1'b1;
   logic               start_fe = 1'b0, start_registration = 1'b0, bbox_valid = 1'b1;
   logic [CAND_AW-1:0] num_cand = '0;
   logic               cand_rd_en, fe_busy, done_fe, done_registration, protocol_err;
   logic [CAND_AW-1:0] cand_addr;
   logic [SCORE_W-1:0] cand_score = '0, best_score;
   logic [ID_W-1:0]    cand_id = '0, best_id;

   oflow_pe_ctrl dut (
      .clk(clk), .reset(reset), .start_fe(start_fe), .start_registration(start_registration),
      .bbox_valid(bbox_valid), .num_cand(num_cand), .cand_rd_en(cand_rd_en), .cand_addr(cand_addr),
      .cand_score(cand_score), .cand_id(cand_id), .fe_busy(fe_busy), .done_fe(done_fe),
      .done_registration(done_registration), .best_id(best_id), .best_score(best_score),
      .protocol_err(protocol_err));

   // PE array
   logic               a_sfe = 1'b0, a_sreg = 1'b0;
   logic [NPE-1:0]     a_bbox = '1;
   logic [CAND_AW-1:0] a_num = '0;
   logic [SCORE_W-1:0] a_score = '0;
   logic [ID_W-1:0]    a_id = '0;
   logic [NPE-1:0]     a_rd, a_busy, a_dfe, a_dreg, a_err;
   logic [CAND_AW-1:0] a_addr [NPE];
   logic [ID_W-1:0]    a_bid  [NPE];
   logic [SCORE_W-1:0] a_bsc  [NPE];

   for (genvar k = 0; k < NPE; k++) begin : g_pe
      oflow_pe_ctrl u_pe (
         .clk(clk), .reset(reset), .start_fe(a_sfe), .start_registration(a_sreg),
         .bbox_valid(a_bbox[k]), .num_cand(a_num), .cand_rd_en(a_rd[k]), .cand_addr(a_addr[k]),
         .cand_score(a_score), .cand_id(a_id), .fe_busy(a_busy[k]), .done_fe(a_dfe[k]),
         .done_registration(a_dreg[k]), .best_id(a_bid[k]), .best_score(a_bsc[k]),
         .protocol_err(a_err[k]));
   end

   // Candidate buffer: data one cycle after the read strobe, zeros otherwise
   // (zero would win any comparison, so a stray update is visible).
   logic [SCORE_W-1:0] mem_s [64];
   logic [ID_W-1:0]    mem_i [64];
   always @(posedge clk) begin
      if (cand_rd_en) begin cand_score <= mem_s[cand_addr]; cand_id <= mem_i[cand_addr]; end
      else begin cand_score <= '0; cand_id <= '0; end
      if (a_rd[0]) begin a_score <= mem_s[a_addr[0]]; a_id <= mem_i[a_addr[0]]; end
      else begin a_score <= '0; a_id <= '0; end
   end

   int passes = 0, total = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total = total + 1;
      assert (obs === exp) passes = passes + 1;
      else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic fill(input bit zeros);
      for (int i = 0; i < 64; i++) begin
         mem_i[i] = ID_W'(i + 100);
         if (zeros) mem_s[i] = '0;
         else if ($urandom_range(0, 7) == 0) mem_s[i] = '1;
         else mem_s[i] = SCORE_W'($urandom_range(0, 20));
      end
   endtask

   // Reference: smallest score among the first n; first index holding it wins;
   // a minimum of all ones means nothing matched.
   task automatic model(input int n, output logic [SCORE_W-1:0] s, output logic [ID_W-1:0] id);
      logic [SCORE_W-1:0] m;
      m = '1;
      for (int i = 0; i < n; i++) if (mem_s[i] < m) m = mem_s[i];
      s = m; id = NO_MATCH;
      if (m != '1) begin
         for (int i = n - 1; i >= 0; i--) if (mem_s[i] == m) id = mem_i[i];
      end
   endtask

   // FE window; inj raises an extra start_fe sampled at edge 2.
   task automatic run_fe(input bit bv, input bit inj);
      int d;
      d = bv ? FE_LAT : 1;
      bbox_valid = bv; start_fe = 1'b1; tick(); start_fe = 1'b0;
      check("fe_err_c0", protocol_err, 0);
      check("fe_busy_c0", fe_busy, bv);
      check("fe_dfe_c0", done_fe, 0);
      check("fe_dreg_c0", done_registration, 0);
      for (int c = 1; c <= FE_LAT + 1; c++) begin
         start_fe = inj && (c == 2);
         tick(); start_fe = 1'b0;
         check("fe_busy", fe_busy, bv && (c < FE_LAT));
         check("fe_done", done_fe, c >= d);
         check("fe_err", protocol_err, inj && (c == 2));
      end
   endtask

   task automatic run_reg(input int n, input bit bv, input bit both);
      int neff, dat, reads;
      logic [SCORE_W-1:0] es;
      logic [ID_W-1:0] ei;
      neff = bv ? ((n > CAND_MAX) ? CAND_MAX : n) : 0;
      dat = (neff == 0) ? 1 : neff + 2;
      reads = 0;
      num_cand = CAND_AW'(n); start_registration = 1'b1; start_fe = both;
      tick();
      start_registration = 1'b0; start_fe = 1'b0; num_cand = CAND_AW'($urandom);
      check("reg_err_c0", protocol_err, both);
      check("reg_rd_c0", cand_rd_en, 0);
      check("reg_done_c0", done_registration, 0);
      for (int c = 1; c <= dat + 1; c++) begin
         tick();
         if (cand_rd_en) reads++;
         check("reg_rd", cand_rd_en, c <= neff);
         if (c <= neff) check("reg_addr", 32'(cand_addr), c - 1);
         check("reg_done", done_registration, c >= dat);
      end
      check("reg_nreads", reads, neff);
      check("reg_dfe_hold", done_fe, 1);
      model(neff, es, ei);
      check("reg_best_score", best_score, es);
      check("reg_best_id", best_id, ei);
   endtask

   initial begin
      logic [SCORE_W-1:0] es;
      logic [ID_W-1:0] ei;
      logic [NPE-1:0] act;
      fill(1'b0);
      // reset state
      tick(); tick(); reset = 1'b0;
      check("rst_busy", fe_busy, 0);
      check("rst_dfe", done_fe, 0);
      check("rst_dreg", done_registration, 0);
      check("rst_rd", cand_rd_en, 0);
      check("rst_err", protocol_err, 0);
      check("rst_bid", best_id, NO_MATCH);
      check("rst_bsc", best_score, SCORE_NONE);

      // registration start in IDLE is rejected
      start_registration = 1'b1; num_cand = 6'd5; tick(); start_registration = 1'b0;
      check("idle_reg_err", protocol_err, 1);
      tick();
      check("idle_reg_err_drop", protocol_err, 0);
      check("idle_reg_dreg", done_registration, 0);
      check("idle_reg_rd", cand_rd_en, 0);

      // basic: fixed scores with a tie at index 3
      mem_s[0] = 16'd9; mem_s[1] = 16'd3; mem_s[2] = 16'd7; mem_s[3] = 16'd3; mem_s[4] = 16'd8;
      run_fe(1'b1, 1'b1);
      run_reg(5, 1'b1, 1'b0);
      check("basic_id", best_id, mem_i[1]);
      check("basic_score", best_score, 3);

      // idle slot
      run_fe(1'b0, 1'b0);
      run_reg(5, 1'b0, 1'b0);
      check("idle_bid", best_id, NO_MATCH);

      // N=0, then clamp at 63 with simultaneous starts in FE_DONE
      run_fe(1'b1, 1'b0);
      run_reg(0, 1'b1, 1'b0);
      run_fe(1'b1, 1'b0);
      fill(1'b0);
      run_reg(63, 1'b1, 1'b1);

      // randomized sets
      for (int t = 0; t < 6; t++) begin
         fill(1'b0);
         run_fe(($urandom_range(0, 4) != 0), 1'b0);
         run_reg($urandom_range(0, 63), bbox_valid, 1'b0);
      end

      // reset during a 10-candidate sweep
      run_fe(1'b1, 1'b0);
      fill(1'b1);
      num_cand = 6'd10; start_registration = 1'b1; tick(); start_registration = 1'b0;
      tick(); tick(); tick();
      reset = 1'b1; tick(); reset = 1'b0;
      check("mid_rst_busy", fe_busy, 0);
      check("mid_rst_dfe", done_fe, 0);
      check("mid_rst_dreg", done_registration, 0);
      check("mid_rst_rd", cand_rd_en, 0);
      check("mid_rst_addr", 32'(cand_addr), 0);
      check("mid_rst_bid", best_id, NO_MATCH);
      check("mid_rst_bsc", best_score, SCORE_NONE);
      tick();
      check("late_score_bsc", best_score, SCORE_NONE);
      check("late_score_bid", best_id, NO_MATCH);
      fill(1'b0);
      mem_s[0] = 16'd9; mem_s[1] = 16'd3; mem_s[2] = 16'd7; mem_s[3] = 16'd3; mem_s[4] = 16'd8;
      run_fe(1'b1, 1'b0);
      run_reg(5, 1'b1, 1'b0);

      // 24-PE array, slots 5 and 17 idle
      fill(1'b0);
      act = '1; act[5] = 1'b0; act[17] = 1'b0;
      a_bbox = act;
      a_sfe = 1'b1; tick(); a_sfe = 1'b0;
      for (int c = 1; c <= FE_LAT + 1; c++) begin
         tick();
         check("arr_and_dfe", &a_dfe, c >= FE_LAT);
      end
      a_num = 6'd7; a_sreg = 1'b1; tick(); a_sreg = 1'b0;
      for (int c = 1; c <= 11; c++) begin
         tick();
         check("arr_and_dreg", &a_dreg, c >= 9);
         check("arr_and_dfe_hold", &a_dfe, 1);
      end
      model(7, es, ei);
      for (int k = 0; k < NPE; k++) begin
         check("arr_bid", a_bid[k], act[k] ? ei : NO_MATCH);
         check("arr_bsc", a_bsc[k], act[k] ? es : SCORE_NONE);
      end
      check("arr_no_err", |a_err, 0);
      a_sfe = 1'b1; tick(); a_sfe = 1'b0;
      check("arr_dfe_drop", |a_dfe, 0);
      check("arr_dreg_drop", |a_dreg, 0);

      $display("%0d/%0d checks passed", passes, total);
      $finish;
   end

endmodule
